// File: rtl/mux_ctrl_pkg.sv
// Shared types and constants for the 2:1 mux sharing arbiter.
package mux_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_e;

    // Mux select encoding; also reused as the last-served pointer encoding.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_share_arbiter_if.sv
// Request/grant bundle between the two requesters and the arbiter.
interface mux2_share_arbiter_if;

    logic req_a;
    logic req_b;
    logic done_a;
    logic done_b;
    logic grant_a;
    logic grant_b;
    logic sel;
    logic busy;
    logic timeout;

    // Requester side.
    modport master (
        output req_a, req_b, done_a, done_b,
        input  grant_a, grant_b, sel, busy, timeout
    );

    // Arbiter side.
    modport slave (
        input  req_a, req_b, done_a, done_b,
        output grant_a, grant_b, sel, busy, timeout
    );

endinterface

// File: rtl/mux2_share_arbiter_hold_counter.sv
// Saturating grant-length counter. clr together with en restarts at 1 (first
// cycle of a new grant); clr alone parks it at 0.
module hold_counter #(
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_max
);

    localparam logic [CNT_W-1:0] MaxVal = CNT_W'(MAX_HOLD);

    logic [CNT_W-1:0] count;

    // Count register: restart, park, or saturating increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= en ? CNT_W'(1) : '0;
        end else if (en && !at_max) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_max = (count == MaxVal);

endmodule

// File: rtl/mux2_share_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux path between requesters A and B,
// with a per-grant hold limit so neither side can starve the other.
module mux2_share_arbiter
    import mux_ctrl_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input logic                 clk,
    input logic                 rst,
    mux2_share_arbiter_if.slave bus
);

    state_e state_q, state_d;
    logic   sel_q, sel_d;
    logic   last_q, last_d;
    logic   timeout_q, timeout_d;
    logic   cnt_clr, cnt_en, at_max;

    hold_counter #(
        .CNT_W    (CNT_W),
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .at_max (at_max)
    );

    // State, select, round-robin pointer and timeout pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= SEL_A;
            last_q    <= SEL_B;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state: arbitration in IDLE, release and direct hand-over in GNT_x.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        timeout_d = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_a && (!bus.req_b || last_q == SEL_B)) begin
                    state_d = GNT_A;
                    sel_d   = SEL_A;
                    last_d  = SEL_A;
                    cnt_clr = 1'b1;
                    cnt_en  = 1'b1;
                end else if (bus.req_b) begin
                    state_d = GNT_B;
                    sel_d   = SEL_B;
                    last_d  = SEL_B;
                    cnt_clr = 1'b1;
                    cnt_en  = 1'b1;
                end
            end
            GNT_A: begin
                if (bus.done_a || !bus.req_a || at_max) begin
                    // done beats the hold limit, so timeout only on a genuine force-release
                    timeout_d = !bus.done_a && bus.req_a && at_max;
                    cnt_clr   = 1'b1;
                    if (bus.req_b) begin
                        state_d = GNT_B;
                        sel_d   = SEL_B;
                        last_d  = SEL_B;
                        cnt_en  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            GNT_B: begin
                if (bus.done_b || !bus.req_b || at_max) begin
                    timeout_d = !bus.done_b && bus.req_b && at_max;
                    cnt_clr   = 1'b1;
                    if (bus.req_a) begin
                        state_d = GNT_A;
                        sel_d   = SEL_A;
                        last_d  = SEL_A;
                        cnt_en  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.grant_a = (state_q == GNT_A);
    assign bus.grant_b = (state_q == GNT_B);
    assign bus.busy    = (state_q != IDLE);
    assign bus.sel     = sel_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux2_share_arbiter.sv
// Directed bench for mux2_share_arbiter with an expectation queue.
module tb_mux2_share_arbiter;

    localparam int unsigned MAX_HOLD = 16;

    // Expected output vector: {grant_a, grant_b, sel, busy, timeout}
    localparam logic [4:0] E_IDLE0 = 5'b00000;
    localparam logic [4:0] E_IDLE1 = 5'b00100;
    localparam logic [4:0] E_A     = 5'b10010;
    localparam logic [4:0] E_B     = 5'b01110;
    localparam logic [4:0] E_TO_B  = 5'b00101;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [4:0] exp_q[$];
    string      tag_q[$];

    mux2_share_arbiter_if bus ();

    mux2_share_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grants must never overlap, checked every cycle away from the edge.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            assert ((bus.grant_a & bus.grant_b) === 1'b0)
            else begin
                bad++;
                $error("FAIL excl observed=%b%b required=not both", bus.grant_a, bus.grant_b);
            end
        end
    end

    // Drive one cycle of inputs, queue the expected outputs, and check after the edge.
    task automatic step(input logic ra, input logic rb, input logic da, input logic db,
                        input logic [4:0] e, input string tag);
        logic [4:0] obs;
        logic [4:0] want;
        string      t;
        bus.req_a  = ra;
        bus.req_b  = rb;
        bus.done_a = da;
        bus.done_b = db;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        obs  = {bus.grant_a, bus.grant_b, bus.sel, bus.busy, bus.timeout};
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        total++;
        assert (obs === want)
        else begin
            bad++;
            $error("FAIL %s observed=%b required=%b", t, obs, want);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.req_a  = 1'b0;
        bus.req_b  = 1'b0;
        bus.done_a = 1'b0;
        bus.done_b = 1'b0;

        // Reset, then A alone
        rst = 1'b1;
        step(0, 0, 0, 0, E_IDLE0, "reset");
        rst = 1'b0;
        step(0, 0, 0, 0, E_IDLE0, "idle_after_reset");
        step(1, 0, 0, 0, E_A, "a_grant");
        step(1, 0, 0, 0, E_A, "a_hold");
        step(1, 0, 1, 0, E_IDLE0, "a_done");
        step(0, 0, 0, 0, E_IDLE0, "a_idle");

        // Tie after reset: A first, then direct hand-over to B
        rst = 1'b1;
        step(0, 0, 0, 0, E_IDLE0, "reset2");
        rst = 1'b0;
        step(1, 1, 0, 0, E_A, "tie_a_first");
        step(1, 1, 1, 0, E_B, "handover_b");
        step(0, 1, 0, 1, E_IDLE1, "b_done_sel_kept");
        step(0, 0, 0, 0, E_IDLE1, "idle_sel_stable");

        // B held without done: exactly MAX_HOLD cycles, then forced release
        for (int i = 0; i < int'(MAX_HOLD); i++) begin
            step(0, 1, 0, 0, E_B, $sformatf("b_hold_%0d", i + 1));
        end
        step(0, 1, 0, 0, E_TO_B, "b_timeout");
        step(0, 1, 0, 0, E_B, "b_regrant_pulse_gone");
        step(0, 1, 0, 1, E_IDLE1, "b_done2");

        // Continuous contention: alternation A,B,A,... with no idle gap
        step(1, 1, 0, 0, E_A, "rr_enter_a");
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                step(1, 1, 0, 0, E_A, $sformatf("rr_hold_%0d", i));
                step(1, 1, 1, 0, E_B, $sformatf("rr_swap_%0d", i));
            end else begin
                step(1, 1, 0, 0, E_B, $sformatf("rr_hold_%0d", i));
                step(1, 1, 0, 1, E_A, $sformatf("rr_swap_%0d", i));
            end
        end
        step(0, 0, 0, 0, E_IDLE0, "rr_abandon");

        // done_b during A grant is ignored; done_a at the hold limit beats timeout
        step(1, 0, 0, 0, E_A, "a2_grant");
        step(1, 0, 0, 1, E_A, "done_b_ignored");
        for (int i = 0; i < int'(MAX_HOLD) - 2; i++) begin
            step(1, 0, 0, 0, E_A, $sformatf("a2_hold_%0d", i + 3));
        end
        step(1, 0, 1, 0, E_IDLE0, "done_at_max_no_timeout");
        step(0, 0, 0, 0, E_IDLE0, "a2_idle");

        // Reset mid-grant with B at count 7
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 0, 0, E_B, $sformatf("b3_hold_%0d", i + 1));
        end
        rst = 1'b1;
        step(0, 1, 0, 0, E_IDLE0, "rst_mid_grant");
        rst = 1'b0;
        step(1, 1, 0, 0, E_A, "post_rst_a_first");
        step(0, 0, 0, 0, E_IDLE0, "final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
